twiddle_ctrl: RTL and testbench
===============================

Name: twiddle_ctrl

Overview:
Front-panel controller for the twiddleboard: one rotary encoder, one pushbutton, and a small value register driving LED/PIN_1..3.
- Decodes raw quadrature from the encoder pins into detent steps.
- Sequences short/long button presses into lock-toggle and clear commands.
- Owns the WIDTH-bit value register that replaces the free-running press counter in top.

Parameters:
WIDTH, 4, bits of value register (maps to LED, PIN_1, PIN_2, PIN_3).
STEPS_PER_DETENT, 4, valid quadrature transitions per detent; power of two, 1..8.
LONG_PRESS_CYCLES, 16000000, cycles held before a long press fires (1 s at 16 MHz); at least 2.
WRAP, 1, 1 = value wraps modulo 2^WIDTH; 0 = saturates at 0 and 2^WIDTH-1.

Ports:
CLK  in  1  16 MHz system clock
RST  in  1  synchronous, active-high reset
rot_a  in  1  raw encoder A (pull-up pad, asynchronous)
rot_b  in  1  raw encoder B (pull-up pad, asynchronous)
btn_n  in  1  debounced pushbutton, active-low (0 = pressed), already synchronous to CLK
value  out  WIDTH  current value
locked  out  1  1 = rotation does not modify value
step_pulse  out  1  one-cycle pulse per applied detent
step_dir  out  1  direction of last detent: 1 = up (CW), 0 = down
short_press  out  1  one-cycle pulse on release of a short press
long_press  out  1  one-cycle pulse when the hold threshold is reached
quad_err  out  1  one-cycle pulse on an illegal quadrature transition (A and B both changed)

Behaviour:
Reset (RST=1 at a CLK edge):
- value=0, locked=0, step_dir=0, all pulse outputs 0.
- Synchronisers=2'b11, detent accumulator=0, button FSM=IDLE, hold counter=0, primed=0.

Quadrature path:
- rot_a/rot_b each pass through a 2-FF synchroniser; ab = {sync_a, sync_b}.
- First cycle after reset with primed=0: prev_ab <= ab, primed <= 1, no evaluation.
- Gray sequence 00->01->11->10->00 = +1; reverse = -1; no change = 0.
- 00<->11 or 01<->10 = illegal: quad_err pulse, accumulator unchanged.
- Signed accumulator, range +-STEPS_PER_DETENT. Reaching +S gives a detent-up event; -S gives detent-down; accumulator then clears to 0 in the same cycle.
- Latency: a pin change first sampled at edge k is seen by the decoder at edge k+2. value/step_pulse update on that edge, registered, visible after it.

Value update:
- On a detent event with locked=0: value +-1 (wrap or saturate per WRAP), step_pulse=1, step_dir set.
- Saturating at a limit: value unchanged, step_pulse still 1, step_dir still updated.
- locked=1: accumulator still runs, detents discarded, no step_pulse.

Button FSM (IDLE, PRESSED, HELD):
- IDLE: btn_n=0 -> PRESSED, hold counter=1.
- PRESSED, btn_n=0: counter increments. When counter == LONG_PRESS_CYCLES-1 -> HELD, long_press pulse, value <= 0.
- PRESSED, btn_n=1: -> IDLE, short_press pulse, locked toggles.
- HELD: wait for btn_n=1 -> IDLE. No short_press; locked unchanged.
- Hold counter width = clog2(LONG_PRESS_CYCLES)+1. It never wraps.

Simultaneous events:
- Clear (long press) beats a detent in the same cycle: value=0, step_pulse=0, accumulator cleared.
- A short_press toggle and a detent in the same cycle: the detent is evaluated against the old locked value.

Reset mid-operation:
- RST in PRESSED/HELD -> IDLE; no pulses emitted.
- Partial accumulator counts are discarded.

Decomposition:
Package twiddle_pkg:
- Button state enum (IDLE/PRESSED/HELD).
- Quadrature delta function (prev_ab, ab -> {illegal, +1, 0, -1}).
- Constant for idle pin level 2'b11.

Sub-module quad_decoder:
- Contains the synchronisers, prime logic, accumulator and detent event outputs (det_up, det_dn, err).
- Instantiated once in twiddle_ctrl.

Button FSM and value register stay in twiddle_ctrl.

Test Plan:
Bench parameters: WIDTH=4, STEPS_PER_DETENT=4, LONG_PRESS_CYCLES=100, WRAP=1 unless noted.
1. Reset, then drive ab 11->10->00->01->11 (CW, 20 cycles each) -> exactly one step_pulse with step_dir=1, value=1, quad_err never 1.
2. From value=15, one CW detent -> value=0 (wrap). Repeat with WRAP=0 -> value stays 15, step_pulse=1.
3. Jump ab 11->00 -> one quad_err pulse, value and accumulator unchanged. A following legal CCW detent from value=0 -> value=15 (WRAP=1).
4. btn_n low for 50 cycles, then high -> short_press pulse on release, locked=1. A CW detent leaves value unchanged with no step_pulse. A second short press -> locked=0.
5. value=7, btn_n low for 150 cycles -> long_press pulse exactly 99 cycles after the press edge, value=0, no short_press on release. A detent completing on the long_press cycle -> value=0, no step_pulse.
6. Assert RST for 1 cycle mid-PRESSED (cycle 60) and with accumulator at +3 -> value=0, no pulses; the next full CW detent yields value=1.

Source files
------------

// File: rtl/twiddle_pkg.sv
// Shared types and helpers for the twiddleboard front-panel controller.
package twiddle_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE    = 2'd0,
        BTN_PRESSED = 2'd1,
        BTN_HELD    = 2'd2
    } btn_state_t;

    typedef enum logic [1:0] {
        QD_NONE    = 2'd0,
        QD_UP      = 2'd1,
        QD_DOWN    = 2'd2,
        QD_ILLEGAL = 2'd3
    } quad_delta_t;

    // Encoder pads are pulled up, so both pins read high at rest.
    localparam logic [1:0] AB_IDLE = 2'b11;

    function automatic logic [1:0] gray_next_cw(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic quad_delta_t quad_delta(input logic [1:0] prev_ab,
                                               input logic [1:0] ab);
        if (prev_ab == ab)
            return QD_NONE;
        else if ((prev_ab ^ ab) == 2'b11)
            return QD_ILLEGAL;
        else if (gray_next_cw(prev_ab) == ab)
            return QD_UP;
        else
            return QD_DOWN;
    endfunction

endpackage

// File: rtl/quad_decoder.sv
// Synchronises raw encoder pins and folds Gray-code transitions into detent events.
module quad_decoder
    import twiddle_pkg::*;
#(
    parameter int STEPS_PER_DETENT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_rot_a,
    input  logic i_rot_b,
    input  logic i_clr,
    output logic o_det_up,
    output logic o_det_dn,
    output logic o_err
);

    localparam int ACC_W = $clog2(STEPS_PER_DETENT) + 2;
    localparam logic signed [ACC_W-1:0] ACC_TOP = $signed(ACC_W'(STEPS_PER_DETENT - 1));
    localparam logic signed [ACC_W-1:0] ACC_BOT = -ACC_TOP;

    logic [1:0]              r_sync_a;
    logic [1:0]              r_sync_b;
    logic [1:0]              r_prev_ab;
    logic                    r_primed;
    logic signed [ACC_W-1:0] r_acc;
    logic [1:0]              w_ab;
    quad_delta_t             w_delta;

    assign w_ab    = {r_sync_a[1], r_sync_b[1]};
    assign w_delta = quad_delta(r_prev_ab, w_ab);

    // A detent fires on the step that would carry the accumulator to +-S.
    assign o_err    = r_primed && (w_delta == QD_ILLEGAL);
    assign o_det_up = r_primed && (w_delta == QD_UP)   && (r_acc == ACC_TOP);
    assign o_det_dn = r_primed && (w_delta == QD_DOWN) && (r_acc == ACC_BOT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync_a  <= {2{AB_IDLE[1]}};
            r_sync_b  <= {2{AB_IDLE[0]}};
            r_prev_ab <= AB_IDLE;
            r_primed  <= 1'b0;
            r_acc     <= '0;
        end else begin
            r_sync_a  <= {r_sync_a[0], i_rot_a};
            r_sync_b  <= {r_sync_b[0], i_rot_b};
            r_prev_ab <= w_ab;
            r_primed  <= 1'b1;
            if (!r_primed || i_clr || o_det_up || o_det_dn)
                r_acc <= '0;
            else if (w_delta == QD_UP)
                r_acc <= r_acc + ACC_W'(1);
            else if (w_delta == QD_DOWN)
                r_acc <= r_acc - ACC_W'(1);
        end
    end

endmodule

// File: rtl/twiddle_ctrl.sv
// Front-panel controller: encoder detents adjust a value register, the button
// toggles lock (short press) or clears the value (long press).
module twiddle_ctrl
    import twiddle_pkg::*;
#(
    parameter int WIDTH             = 4,
    parameter int STEPS_PER_DETENT  = 4,
    parameter int LONG_PRESS_CYCLES = 16000000,
    parameter int WRAP              = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             rot_a,
    input  logic             rot_b,
    input  logic             btn_n,
    output logic [WIDTH-1:0] value,
    output logic             locked,
    output logic             step_pulse,
    output logic             step_dir,
    output logic             short_press,
    output logic             long_press,
    output logic             quad_err
);

    localparam int               CNT_W    = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [WIDTH-1:0] VAL_MAX  = {WIDTH{1'b1}};

    btn_state_t       r_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [WIDTH-1:0] r_value;
    logic             r_locked;
    logic             r_step_pulse;
    logic             r_step_dir;
    logic             r_short_press;
    logic             r_long_press;
    logic             r_quad_err;
    logic             w_det_up;
    logic             w_det_dn;
    logic             w_err;
    logic             w_clear;

    assign w_clear = (r_state == BTN_PRESSED) && !btn_n && (r_hold_cnt == CNT_LAST);

    quad_decoder #(
        .STEPS_PER_DETENT(STEPS_PER_DETENT)
    ) u_quad_decoder (
        .CLK     (CLK),
        .RST     (RST),
        .i_rot_a (rot_a),
        .i_rot_b (rot_b),
        .i_clr   (w_clear),
        .o_det_up(w_det_up),
        .o_det_dn(w_det_dn),
        .o_err   (w_err)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= BTN_IDLE;
            r_hold_cnt    <= '0;
            r_value       <= '0;
            r_locked      <= 1'b0;
            r_step_pulse  <= 1'b0;
            r_step_dir    <= 1'b0;
            r_short_press <= 1'b0;
            r_long_press  <= 1'b0;
            r_quad_err    <= 1'b0;
        end else begin
            r_step_pulse  <= 1'b0;
            r_short_press <= 1'b0;
            r_long_press  <= 1'b0;
            r_quad_err    <= w_err;

            case (r_state)
                BTN_IDLE: begin
                    if (!btn_n) begin
                        r_state    <= BTN_PRESSED;
                        r_hold_cnt <= CNT_W'(1);
                    end
                end
                BTN_PRESSED: begin
                    if (btn_n) begin
                        r_state       <= BTN_IDLE;
                        r_hold_cnt    <= '0;
                        r_short_press <= 1'b1;
                        r_locked      <= ~r_locked;
                    end else if (r_hold_cnt == CNT_LAST) begin
                        r_state      <= BTN_HELD;
                        r_long_press <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                BTN_HELD: begin
                    if (btn_n) begin
                        r_state    <= BTN_IDLE;
                        r_hold_cnt <= '0;
                    end
                end
                default: r_state <= BTN_IDLE;
            endcase

            // Detents use the pre-toggle lock state; a clear overrides any detent.
            if (w_clear) begin
                r_value <= '0;
            end else if ((w_det_up || w_det_dn) && !r_locked) begin
                r_step_pulse <= 1'b1;
                r_step_dir   <= w_det_up;
                if (w_det_up) begin
                    if (WRAP != 0 || r_value != VAL_MAX)
                        r_value <= r_value + WIDTH'(1);
                end else begin
                    if (WRAP != 0 || r_value != '0)
                        r_value <= r_value - WIDTH'(1);
                end
            end
        end
    end

    assign value       = r_value;
    assign locked      = r_locked;
    assign step_pulse  = r_step_pulse;
    assign step_dir    = r_step_dir;
    assign short_press = r_short_press;
    assign long_press  = r_long_press;
    assign quad_err    = r_quad_err;

endmodule

// File: tb/tb_twiddle_ctrl.sv
// Scoreboard bench for twiddle_ctrl: a wrapping main instance plus a saturating twin.
module tb_twiddle_ctrl;

    localparam int WIDTH = 4;
    localparam int SPD   = 4;
    localparam int LPC   = 100;

    logic CLK   = 1'b0;
    logic RST   = 1'b1;
    logic rot_a = 1'b1;
    logic rot_b = 1'b1;
    logic btn_n = 1'b1;

    logic [WIDTH-1:0] value;
    logic locked, step_pulse, step_dir, short_press, long_press, quad_err;
    logic [WIDTH-1:0] sat_value;
    logic sat_locked, sat_step_pulse, sat_step_dir, sat_short, sat_long, sat_qerr;

    twiddle_ctrl #(.WIDTH(WIDTH), .STEPS_PER_DETENT(SPD), .LONG_PRESS_CYCLES(LPC), .WRAP(1)) dut (
        .CLK(CLK), .RST(RST), .rot_a(rot_a), .rot_b(rot_b), .btn_n(btn_n),
        .value(value), .locked(locked), .step_pulse(step_pulse), .step_dir(step_dir),
        .short_press(short_press), .long_press(long_press), .quad_err(quad_err)
    );

    twiddle_ctrl #(.WIDTH(WIDTH), .STEPS_PER_DETENT(SPD), .LONG_PRESS_CYCLES(LPC), .WRAP(0)) dut_sat (
        .CLK(CLK), .RST(RST), .rot_a(rot_a), .rot_b(rot_b), .btn_n(btn_n),
        .value(sat_value), .locked(sat_locked), .step_pulse(sat_step_pulse), .step_dir(sat_step_dir),
        .short_press(sat_short), .long_press(sat_long), .quad_err(sat_qerr)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic             dir;
        logic [WIDTH-1:0] value;
    } step_t;

    step_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_qerr = 0, n_short = 0, n_long = 0, n_sat = 0, n_steps = 0;
    int long_cyc = 0, press_cyc = 0;

    logic [1:0]       cur_ab     = 2'b11;
    logic [WIDTH-1:0] exp_value  = '0;
    logic             exp_locked = 1'b0;

    function automatic logic [1:0] next_ab(input logic [1:0] ab, input logic up);
        logic [1:0] r;
        if (up) begin
            case (ab)
                2'b00: r = 2'b01;
                2'b01: r = 2'b11;
                2'b11: r = 2'b10;
                default: r = 2'b00;
            endcase
        end else begin
            case (ab)
                2'b00: r = 2'b10;
                2'b10: r = 2'b11;
                2'b11: r = 2'b01;
                default: r = 2'b00;
            endcase
        end
        return r;
    endfunction

    // Advance one clock per iteration, sample 1 time unit after the edge and
    // match every step_pulse against the head of the scoreboard.
    task automatic run_cycles(input int n);
        step_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (quad_err)       n_qerr++;
            if (short_press)    n_short++;
            if (long_press)     begin n_long++; long_cyc = cyc; end
            if (sat_step_pulse) n_sat++;
            if (step_pulse) begin
                n_steps++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_step: got value=%0d dir=%0d, expected no step_pulse", value, step_dir);
                end else begin
                    e = sb_q.pop_front();
                    if ({step_dir, value} !== e) begin
                        errors++;
                        $display("FAIL step_event: got dir=%0d value=%0d, expected dir=%0d value=%0d",
                                 step_dir, value, e.dir, e.value);
                    end
                end
            end
        end
    endtask

    task automatic move(input logic up);
        cur_ab = next_ab(cur_ab, up);
        rot_a  = cur_ab[1];
        rot_b  = cur_ab[0];
    endtask

    task automatic push_step(input logic up);
        if (!exp_locked) begin
            exp_value = up ? exp_value + WIDTH'(1) : exp_value - WIDTH'(1);
            sb_q.push_back({up, exp_value});
        end
    endtask

    task automatic detent(input logic up);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) push_step(up);
            move(up);
            run_cycles(20);
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        run_cycles(3);
        checks++;
        if (value !== 4'd0 || locked !== 1'b0 || step_dir !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got value=%0d locked=%0d dir=%0d, expected 0 0 0", value, locked, step_dir);
        end
        checks++;
        if ({step_pulse, short_press, long_press, quad_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: got %b, expected 0000", {step_pulse, short_press, long_press, quad_err});
        end
        checks++;
        if (sat_value !== 4'd0 || {sat_locked, sat_step_pulse, sat_step_dir, sat_short, sat_long, sat_qerr} !== 6'd0) begin
            errors++;
            $display("FAIL reset_sat: got value=%0d flags=%b, expected 0 000000", sat_value,
                     {sat_locked, sat_step_pulse, sat_step_dir, sat_short, sat_long, sat_qerr});
        end
        RST = 1'b0;
        run_cycles(3);
    endtask

    task automatic test_cw_detent;
        n_qerr = 0; n_steps = 0;
        detent(1'b1);
        run_cycles(5);
        checks++;
        if (n_steps !== 1 || value !== 4'd1 || step_dir !== 1'b1) begin
            errors++;
            $display("FAIL cw_detent: got steps=%0d value=%0d dir=%0d, expected 1 1 1", n_steps, value, step_dir);
        end
        checks++;
        if (n_qerr !== 0) begin
            errors++;
            $display("FAIL cw_no_err: got quad_err count=%0d, expected 0", n_qerr);
        end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 14; i++) detent(1'b1);
        run_cycles(5);
        checks++;
        if (value !== 4'd15 || sat_value !== 4'd15) begin
            errors++;
            $display("FAIL pre_wrap: got value=%0d sat=%0d, expected 15 15", value, sat_value);
        end
        n_sat = 0;
        detent(1'b1);
        run_cycles(5);
        checks++;
        if (value !== 4'd0) begin
            errors++;
            $display("FAIL wrap_value: got %0d, expected 0", value);
        end
        checks++;
        if (sat_value !== 4'd15 || n_sat !== 1 || sat_step_dir !== 1'b1) begin
            errors++;
            $display("FAIL saturate: got value=%0d pulses=%0d dir=%0d, expected 15 1 1", sat_value, n_sat, sat_step_dir);
        end
    endtask

    task automatic test_quad_err;
        n_qerr = 0; n_steps = 0;
        cur_ab = 2'b00; rot_a = 1'b0; rot_b = 1'b0;
        run_cycles(20);
        checks++;
        if (n_qerr !== 1 || value !== 4'd0 || n_steps !== 0) begin
            errors++;
            $display("FAIL quad_err_jump: got errs=%0d value=%0d steps=%0d, expected 1 0 0", n_qerr, value, n_steps);
        end
        detent(1'b0);
        run_cycles(5);
        checks++;
        if (value !== 4'd15 || step_dir !== 1'b0) begin
            errors++;
            $display("FAIL ccw_after_err: got value=%0d dir=%0d, expected 15 0", value, step_dir);
        end
        cur_ab = 2'b11; rot_a = 1'b1; rot_b = 1'b1;
        run_cycles(20);
        checks++;
        if (n_qerr !== 2 || value !== 4'd15) begin
            errors++;
            $display("FAIL quad_err_back: got errs=%0d value=%0d, expected 2 15", n_qerr, value);
        end
    endtask

    task automatic test_lock;
        n_short = 0; n_long = 0;
        btn_n = 1'b0;
        run_cycles(50);
        btn_n = 1'b1;
        run_cycles(5);
        exp_locked = 1'b1;
        checks++;
        if (n_short !== 1 || locked !== 1'b1 || n_long !== 0) begin
            errors++;
            $display("FAIL lock_on: got short=%0d locked=%0d long=%0d, expected 1 1 0", n_short, locked, n_long);
        end
        n_steps = 0;
        detent(1'b1);
        run_cycles(5);
        checks++;
        if (n_steps !== 0 || value !== 4'd15) begin
            errors++;
            $display("FAIL locked_detent: got steps=%0d value=%0d, expected 0 15", n_steps, value);
        end
        btn_n = 1'b0;
        run_cycles(20);
        btn_n = 1'b1;
        run_cycles(5);
        exp_locked = 1'b0;
        checks++;
        if (n_short !== 2 || locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_off: got short=%0d locked=%0d, expected 2 0", n_short, locked);
        end
    endtask

    task automatic test_long_press;
        for (int i = 0; i < 8; i++) detent(1'b1);
        run_cycles(5);
        checks++;
        if (value !== 4'd7) begin
            errors++;
            $display("FAIL pre_long: got value=%0d, expected 7", value);
        end
        n_long = 0; n_short = 0; n_steps = 0;
        btn_n = 1'b0;
        press_cyc = cyc + 1;
        run_cycles(1);
        move(1'b1); run_cycles(20);
        move(1'b1); run_cycles(20);
        move(1'b1); run_cycles(20);
        run_cycles(36);
        // The fourth step reaches the decoder on the same edge as long_press.
        move(1'b1);
        run_cycles(54);
        btn_n = 1'b1;
        run_cycles(10);
        exp_value = '0;
        checks++;
        if (n_long !== 1 || (long_cyc - press_cyc) !== 99) begin
            errors++;
            $display("FAIL long_timing: got count=%0d delay=%0d, expected 1 99", n_long, long_cyc - press_cyc);
        end
        checks++;
        if (value !== 4'd0 || n_steps !== 0) begin
            errors++;
            $display("FAIL long_clear: got value=%0d steps=%0d, expected 0 0", value, n_steps);
        end
        checks++;
        if (n_short !== 0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL long_release: got short=%0d locked=%0d, expected 0 0", n_short, locked);
        end
    endtask

    task automatic test_reset_mid;
        detent(1'b1);
        run_cycles(5);
        checks++;
        if (value !== 4'd1) begin
            errors++;
            $display("FAIL pre_rst_value: got %0d, expected 1", value);
        end
        n_short = 0; n_long = 0; n_steps = 0;
        btn_n = 1'b0;
        run_cycles(1);
        move(1'b1); run_cycles(20);
        move(1'b1); run_cycles(20);
        move(1'b1); run_cycles(19);
        RST = 1'b1; btn_n = 1'b1;
        cur_ab = 2'b11; rot_a = 1'b1; rot_b = 1'b1;
        run_cycles(1);
        RST = 1'b0;
        exp_value = '0;
        checks++;
        if (value !== 4'd0 || locked !== 1'b0 || step_dir !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: got value=%0d locked=%0d dir=%0d, expected 0 0 0", value, locked, step_dir);
        end
        run_cycles(10);
        checks++;
        if (n_short !== 0 || n_long !== 0 || n_steps !== 0) begin
            errors++;
            $display("FAIL mid_reset_pulses: got short=%0d long=%0d steps=%0d, expected 0 0 0", n_short, n_long, n_steps);
        end
        detent(1'b1);
        run_cycles(5);
        checks++;
        if (value !== 4'd1 || n_steps !== 1) begin
            errors++;
            $display("FAIL post_reset_detent: got value=%0d steps=%0d, expected 1 1", value, n_steps);
        end
    endtask

    initial begin
        test_reset;
        test_cw_detent;
        test_wrap;
        test_quad_err;
        test_lock;
        test_long_press;
        test_reset_mid;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_steps: got %0d pending, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
